keypad_calc_ctrl: RTL and testbench

Parametrised keypad-entry and operation-sequencing controller for the calculator datapath. It sits between the keypad scanner/edge detector and a multi-operation arithmetic unit, and drives the 7-segment display data bus. It generalises operand digit count, display width and operation count. It adds backspace, operation select, a start/done handshake with timeout, and an error state.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/bcd_entry_reg.sv | 57 +++++
 rtl/keypad_calc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_keypad_calc_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, display prefixes and controller states for the calculator keypad path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package calc_pkg;

  // Keypad codes with a special meaning. Codes 0-9 are digits and C is ignored.
  localparam logic [3:0] KEY_BS  = 4'hA;
  localparam logic [3:0] KEY_OP  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hD;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] BLANK   = 4'hF;

  // Leftmost display nibble, identifying what the rest of the display shows.
  localparam logic [3:0] PFX_A   = 4'hA;
  localparam logic [3:0] PFX_B   = 4'hB;
  localparam logic [3:0] PFX_ERR = 4'hE;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    START,
    BUSY,
    SHOW,
    ERROR
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Operand entry register: digits shift in at the LSB, backspace shifts out towards the LSB.
// Latency: one cycle from push/pop/clear to the updated register.
// Backpressure: push is ignored when full, pop is ignored when empty.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter int N_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [3:0]            digit,
  input  logic                  pop,
  input  logic                  clear,
  output logic                  full,
  output logic                  empty,
  output logic [4*N_DIGITS-1:0] bcd_raw,
  output logic [4*N_DIGITS-1:0] bcd_zero
);

  localparam int W = 4 * N_DIGITS;

  logic [W-1:0] reg_q, reg_d;

  // Digits are right-aligned, so the MSB nibble fills last and the LSB nibble empties last.
  assign full    = (reg_q[W-1 -: 4] != BLANK);
  assign empty   = (reg_q[3:0] == BLANK);
  assign bcd_raw = reg_q;

  // Next register value: clear wins, then digit entry, then backspace.
  always_comb begin
    reg_d = reg_q;
    if (clear) begin
      reg_d = '1;
    end else if (push && !full) begin
      reg_d = (reg_q << 4) | W'(digit);
    end else if (pop && !empty) begin
      reg_d            = reg_q >> 4;
      reg_d[W-1 -: 4]  = BLANK;
    end
  end

  // Blank positions are presented to the arithmetic unit as zero digits.
  always_comb begin
    bcd_zero = reg_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (reg_q[4*i +: 4] == BLANK) bcd_zero[4*i +: 4] = 4'h0;
    end
  end

  // Register holds all-blank after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reg_q <= '1;
    else      reg_q <= reg_d;
  end

endmodule

// File: rtl/keypad_calc_ctrl.sv
// Keypad entry and operation sequencing between key scanner, arithmetic unit and 7-seg display.
// Latency: accepted key takes effect next cycle; op_start one cycle after the final enter.
// Backpressure: keys dropped during lockout; result only taken in BUSY, bounded by a timeout.
module keypad_calc_ctrl
  import calc_pkg::*;
#(
  parameter int N_DIGITS    = 2,
  parameter int DISP_DIGITS = 4,
  parameter int N_OPS       = 2,
  parameter int LOCK_CYCLES = 17_550_000,
  parameter int OP_TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic [4*N_DIGITS-1:0]    operand_a,
  output logic [4*N_DIGITS-1:0]    operand_b,
  output logic [1:0]               op_sel,
  output logic                     op_start,
  input  logic                     res_valid,
  input  logic                     res_error,
  input  logic [4*DISP_DIGITS-1:0] res_data,
  output logic [4*DISP_DIGITS-1:0] display_data,
  output logic                     busy
);

  localparam int OW = 4 * N_DIGITS;
  localparam int DW = 4 * DISP_DIGITS;
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(OP_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] res_q, res_d;
  logic          clr_all;

  logic          a_full, a_empty, b_full, b_empty;
  logic [OW-1:0] a_raw, b_raw;

  // A key counts only outside lockout; the "no key" code never counts.
  logic accept, key_dig, key_bs, key_op, key_clr, key_ent;
  assign accept  = key_valid && (lock_q == '0) && (key_code != BLANK);
  assign key_dig = accept && is_digit(key_code);
  assign key_bs  = accept && (key_code == KEY_BS);
  assign key_op  = accept && (key_code == KEY_OP);
  assign key_clr = accept && (key_code == KEY_CLR);
  assign key_ent = accept && (key_code == KEY_ENT);

  bcd_entry_reg #(.N_DIGITS(N_DIGITS)) u_reg_a (
    .clk      (clk),
    .rst      (rst),
    .push     (key_dig && (state_q == ENTER_A) && !a_full),
    .digit    (key_code),
    .pop      (key_bs && (state_q == ENTER_A)),
    .clear    (clr_all),
    .full     (a_full),
    .empty    (a_empty),
    .bcd_raw  (a_raw),
    .bcd_zero (operand_a)
  );

  bcd_entry_reg #(.N_DIGITS(N_DIGITS)) u_reg_b (
    .clk      (clk),
    .rst      (rst),
    .push     (key_dig && (state_q == ENTER_B) && !b_full),
    .digit    (key_code),
    .pop      (key_bs && (state_q == ENTER_B)),
    .clear    (clr_all),
    .full     (b_full),
    .empty    (b_empty),
    .bcd_raw  (b_raw),
    .bcd_zero (operand_b)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ENTER_A;
    else      state_q <= state_d;
  end

  // Next state; clear is checked first everywhere so an abort beats a coincident result.
  always_comb begin
    state_d = state_q;
    clr_all = 1'b0;
    case (state_q)
      ENTER_A: begin
        if (key_clr)                 clr_all = 1'b1;
        else if (key_ent && !a_empty) state_d = ENTER_B;
      end
      ENTER_B: begin
        if (key_clr) begin
          clr_all = 1'b1;
          state_d = ENTER_A;
        end else if (key_ent && !b_empty) begin
          state_d = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (key_clr) begin
          clr_all = 1'b1;
          state_d = ENTER_A;
        end else if (res_valid) begin
          state_d = res_error ? ERROR : SHOW;
        end else if (tmo_q == TW'(OP_TIMEOUT - 1)) begin
          state_d = ERROR;
        end
      end
      SHOW, ERROR: begin
        if (key_clr || key_ent) begin
          clr_all = 1'b1;
          state_d = ENTER_A;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    op_start     = 1'b0;
    busy         = 1'b0;
    display_data = '1;
    case (state_q)
      ENTER_A: begin
        display_data[OW-1:0]    = a_raw;
        display_data[DW-1 -: 4] = PFX_A;
      end
      ENTER_B: begin
        display_data[OW-1:0]    = b_raw;
        display_data[DW-1 -: 4] = PFX_B;
      end
      START: begin
        op_start                = 1'b1;
        busy                    = 1'b1;
        display_data[DW-1 -: 4] = {2'b00, op_q};
      end
      BUSY: begin
        busy                    = 1'b1;
        display_data[DW-1 -: 4] = {2'b00, op_q};
      end
      SHOW:    display_data = res_q;
      ERROR:   display_data[DW-1 -: 4] = PFX_ERR;
      default: display_data = '1;
    endcase
  end

  // Lockout, operation select, timeout and result latch updates.
  always_comb begin
    lock_d = lock_q;
    if (accept)              lock_d = LW'(LOCK_CYCLES);
    else if (lock_q != '0)   lock_d = lock_q - LW'(1);

    op_d = op_q;
    if (clr_all) begin
      op_d = 2'd0;
    end else if (key_op && ((state_q == ENTER_A) || (state_q == ENTER_B))) begin
      op_d = (op_q == 2'(N_OPS - 1)) ? 2'd0 : op_q + 2'd1;
    end

    // Counts from the START cycle so the timeout is measured from op_start.
    tmo_d = ((state_q == START) || (state_q == BUSY)) ? tmo_q + TW'(1) : '0;

    res_d = res_q;
    if (clr_all)                                       res_d = '1;
    else if ((state_q == BUSY) && (state_d == SHOW))   res_d = res_data;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= '0;
      tmo_q  <= '0;
      op_q   <= 2'd0;
      res_q  <= '1;
    end else begin
      lock_q <= lock_d;
      tmo_q  <= tmo_d;
      op_q   <= op_d;
      res_q  <= res_d;
    end
  end

  assign op_sel = op_q;

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
// Scoreboard bench for keypad_calc_ctrl: directed key/result sequences with hand-computed displays.
// Latency: expected display changes may carry a cycle count relative to op_start.
// Backpressure: keys are spaced past the lockout except where dropping is intended.
module tb_keypad_calc_ctrl;

  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [7:0]  operand_a, operand_b;
  logic [1:0]  op_sel;
  logic        op_start;
  logic        res_valid, res_error;
  logic [15:0] res_data;
  logic [15:0] display_data;
  logic        busy;

  always #5 clk = ~clk;

  keypad_calc_ctrl #(
    .N_DIGITS(2), .DISP_DIGITS(4), .N_OPS(2), .LOCK_CYCLES(LOCK), .OP_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .operand_a(operand_a), .operand_b(operand_b), .op_sel(op_sel), .op_start(op_start),
    .res_valid(res_valid), .res_error(res_error), .res_data(res_data),
    .display_data(display_data), .busy(busy)
  );

  typedef struct { logic [15:0] val; int lat; } disp_exp_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [1:0] op; } op_exp_t;
  typedef struct {
    logic [15:0] disp; logic [7:0] a; logic [7:0] b; logic [1:0] op;
    logic bsy; logic st; int id;
  } snap_t;

  disp_exp_t q_disp[$];
  op_exp_t   q_ops[$];
  snap_t     q_snap[$];

  int          n_chk = 0, n_fail = 0, n_start = 0, n_tmo = 0;
  int          cyc = 0, start_cyc = 0;
  bit          mon_en = 1'b0, done = 1'b0;
  logic [15:0] prev_disp;

  // Monitor: consumes expectations whenever the DUT presents a start pulse or a display change.
  always @(negedge clk) begin
    disp_exp_t de;
    op_exp_t   oe;
    snap_t     se;
    cyc++;
    if (!mon_en) begin
      prev_disp = display_data;
    end else begin
      if (op_start) begin
        n_start++;
        start_cyc = cyc;
        n_chk++;
        if (q_ops.size() == 0) begin
          n_fail++;
          $display("FAIL op_start_unexpected: got pulse at cycle %0d, required none", cyc);
        end else begin
          oe = q_ops.pop_front();
          if ({operand_a, operand_b, op_sel} !== {oe.a, oe.b, oe.op}) begin
            n_fail++;
            $display("FAIL op_start_operands: got a=%h b=%h op=%0d, required a=%h b=%h op=%0d",
                     operand_a, operand_b, op_sel, oe.a, oe.b, oe.op);
          end
        end
      end
      if (display_data !== prev_disp) begin
        n_chk++;
        if (q_disp.size() == 0) begin
          n_fail++;
          $display("FAIL display_unexpected: got %h, required no change from %h",
                   display_data, prev_disp);
        end else begin
          de = q_disp.pop_front();
          if (display_data !== de.val) begin
            n_fail++;
            $display("FAIL display_value: got %h, required %h", display_data, de.val);
          end
          if (de.lat >= 0) begin
            n_chk++;
            if (cyc - start_cyc != de.lat) begin
              n_fail++;
              $display("FAIL display_latency: got %0d cycles after op_start, required %0d",
                       cyc - start_cyc, de.lat);
            end
          end
        end
        prev_disp = display_data;
      end
    end
    if (q_snap.size() > 0) begin
      se = q_snap.pop_front();
      n_chk++;
      if ({display_data, operand_a, operand_b, op_sel, busy, op_start} !==
          {se.disp, se.a, se.b, se.op, se.bsy, se.st}) begin
        n_fail++;
        $display("FAIL snapshot_%0d: got disp=%h a=%h b=%h op=%0d busy=%b start=%b, required disp=%h a=%h b=%h op=%0d busy=%b start=%b",
                 se.id, display_data, operand_a, operand_b, op_sel, busy, op_start,
                 se.disp, se.a, se.b, se.op, se.bsy, se.st);
      end
    end
    if (done) begin
      n_chk++;
      if (q_disp.size() != 0) begin
        n_fail++;
        $display("FAIL display_pending: got %0d expected changes never seen, required 0", q_disp.size());
      end
      n_chk++;
      if (q_ops.size() != 0 || n_start != 5) begin
        n_fail++;
        $display("FAIL op_start_count: got %0d pulses (%0d pending), required 5", n_start, q_ops.size());
      end
      n_chk++;
      if (n_tmo != 0) begin
        n_fail++;
        $display("FAIL op_start_wait: got %0d timeouts, required 0", n_tmo);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic exp_d(input logic [15:0] v, input int lat = -1);
    disp_exp_t e;
    e.val = v;
    e.lat = lat;
    q_disp.push_back(e);
  endtask

  task automatic exp_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    op_exp_t e;
    e.a = a; e.b = b; e.op = op;
    q_ops.push_back(e);
  endtask

  task automatic snap(input logic [15:0] d, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic bsy, input logic st, input int id);
    snap_t e;
    e.disp = d; e.a = a; e.b = b; e.op = op; e.bsy = bsy; e.st = st; e.id = id;
    q_snap.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] c);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  task automatic press(input logic [3:0] c);
    pulse(c);
    cycles(LOCK);
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (op_start) seen = 1'b1;
      else cycles(1);
    end
    if (!seen) n_tmo++;
  endtask

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_code = 4'hF;
    res_valid = 1'b0; res_error = 1'b0; res_data = '0;
    cycles(3);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 0);
    cycles(1);
    rst = 1'b1;
    cycles(2);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1);
    mon_en = 1'b1;

    // Full operation with a good result three cycles after op_start.
    exp_d(16'hAFF1); press(4'h1);
    exp_d(16'hAF12); press(4'h2);
    exp_d(16'hBFFF); press(4'hE);
    exp_d(16'hBFF4); press(4'h4);
    exp_op(8'h12, 8'h04, 2'd0); exp_d(16'h0FFF);
    pulse(4'hE);
    wait_start();
    snap(16'h0FFF, 8'h12, 8'h04, 2'd0, 1'b1, 1'b1, 10);
    cycles(3);
    exp_d(16'h3F0F, 4);
    res_valid = 1'b1; res_data = 16'h3F0F;
    cycles(1);
    res_valid = 1'b0;
    snap(16'h3F0F, 8'h12, 8'h04, 2'd0, 1'b0, 1'b0, 11);
    exp_d(16'hAFFF); press(4'hD);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 12);

    // Digit into a full operand is ignored; backspace removes the last digit.
    exp_d(16'hAFF1); press(4'h1);
    exp_d(16'hAF12); press(4'h2);
    press(4'h3);
    snap(16'hAF12, 8'h12, 8'h00, 2'd0, 1'b0, 1'b0, 20);
    exp_d(16'hAFF1); press(4'hA);
    snap(16'hAFF1, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 21);
    exp_d(16'hAFFF); press(4'hD);

    // Key inside lockout is dropped; key on the first free cycle is taken.
    exp_d(16'hAFF5); exp_d(16'hAF55);
    pulse(4'h5);
    pulse(4'h7);
    cycles(1);
    pulse(4'h5);
    cycles(LOCK);
    snap(16'hAF55, 8'h55, 8'h00, 2'd0, 1'b0, 1'b0, 30);
    exp_d(16'hAFFF); press(4'hD);
    // The "no key" code does not start lockout.
    exp_d(16'hAFF3);
    pulse(4'hF);
    pulse(4'h3);
    cycles(LOCK);
    exp_d(16'hAFFF); press(4'hD);

    // Arithmetic unit reports an error.
    exp_d(16'hAFF9); press(4'h9);
    exp_d(16'hBFFF); press(4'hE);
    exp_d(16'hBFF0); press(4'h0);
    exp_op(8'h09, 8'h00, 2'd0); exp_d(16'h0FFF);
    pulse(4'hE);
    wait_start();
    cycles(3);
    exp_d(16'hEFFF, 4);
    res_valid = 1'b1; res_error = 1'b1; res_data = 16'h1234;
    cycles(1);
    res_valid = 1'b0; res_error = 1'b0;
    snap(16'hEFFF, 8'h09, 8'h00, 2'd0, 1'b0, 1'b0, 40);
    exp_d(16'hAFFF); press(4'hD);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 41);

    // Unit never answers: timeout.
    exp_d(16'hAFF7); press(4'h7);
    exp_d(16'hBFFF); press(4'hE);
    exp_d(16'hBFF3); press(4'h3);
    exp_op(8'h07, 8'h03, 2'd0); exp_d(16'h0FFF);
    pulse(4'hE);
    wait_start();
    exp_d(16'hEFFF, 8);
    cycles(12);
    snap(16'hEFFF, 8'h07, 8'h03, 2'd0, 1'b0, 1'b0, 50);
    exp_d(16'hAFFF); press(4'hD);

    // Clear arriving with the result aborts; a later result is ignored.
    exp_d(16'hAFF8); press(4'h8);
    exp_d(16'hBFFF); press(4'hE);
    exp_d(16'hBFF2); press(4'h2);
    exp_op(8'h08, 8'h02, 2'd0); exp_d(16'h0FFF);
    pulse(4'hE);
    wait_start();
    cycles(5);
    exp_d(16'hAFFF, 6);
    key_valid = 1'b1; key_code = 4'hD; res_valid = 1'b1; res_data = 16'h5678;
    cycles(1);
    key_valid = 1'b0; key_code = 4'hF; res_valid = 1'b0;
    cycles(LOCK);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 51);
    res_valid = 1'b1; res_data = 16'h9999;
    cycles(1);
    res_valid = 1'b0;
    cycles(3);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 52);

    // Operation select wraps modulo 2; reset in BUSY restores everything.
    press(4'hB); press(4'hB); press(4'hB);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 60);
    exp_d(16'hAFF1); press(4'h1);
    exp_d(16'hBFFF); press(4'hE);
    exp_d(16'hBFF1); press(4'h1);
    exp_op(8'h01, 8'h01, 2'd1); exp_d(16'h1FFF);
    pulse(4'hE);
    wait_start();
    cycles(2);
    exp_d(16'hAFFF);
    rst = 1'b0;
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 61);
    cycles(3);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 62);
    rst = 1'b1;
    cycles(20);
    snap(16'hAFFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 63);
    cycles(2);
    done = 1'b1;
  end

endmodule
